// File: rtl/usb_rx_router_if.sv
// Bus bundle between the router, the FTDI->Lycan FIFO read port and the peripheral array.
// The master modport is the router's view; the slave modport is the FIFO/peripheral side.
interface usb_rx_router_if #(
  parameter int NUM_PERIPHS = 8
);
  logic [31:0]            fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [31:0]            tx_data;
  logic [NUM_PERIPHS-1:0] tx_valid;
  logic [NUM_PERIPHS-1:0] tx_full;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    input  tx_full,
    output fifo_rd_en,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    output tx_full,
    input  fifo_rd_en,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/usb_rx_router.sv
// Pops host command words one at a time from a 1-cycle-latency FIFO and delivers each
// to the peripheral named in bits [31:29], dropping invalid or timed-out words.
module usb_rx_router #(
  parameter int NUM_PERIPHS    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_l,
  usb_rx_router_if.master bus,
  output logic        drop_pulse_o,
  output logic [15:0] drop_count_o,
  output logic        idle_o
);

  localparam int WaitW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TimeoutOn = (TIMEOUT_CYCLES != 0);

  logic             pending_q, pending_d;
  logic             holdValid_q, holdValid_d;
  logic [31:0]      holdData_q, holdData_d;
  logic [WaitW-1:0] waitCnt_q, waitCnt_d;
  logic [15:0]      dropCount_q, dropCount_d;

  logic [2:0]             holdAddr;
  logic [7:0]             fullPad;
  logic                   addrValid;
  logic                   targetFull;
  logic                   blocked;
  logic                   deliver;
  logic                   drop;
  logic                   rdEn;
  logic [NUM_PERIPHS-1:0] txValid;

  always_comb begin
    holdAddr   = holdData_q[31:29];
    addrValid  = int'(holdAddr) < NUM_PERIPHS;
    // Padding to 8 bits makes an out-of-range address read as "not full".
    fullPad    = '0;
    fullPad[NUM_PERIPHS-1:0] = bus.tx_full;
    targetFull = fullPad[holdAddr];

    blocked = holdValid_q & addrValid & targetFull;
    deliver = holdValid_q & addrValid & ~targetFull;
    drop    = holdValid_q & (~addrValid |
              (TimeoutOn & (waitCnt_q == WaitLast) & targetFull));
    rdEn    = ~bus.fifo_empty & ~pending_q & (~holdValid_q | deliver | drop);

    txValid = '0;
    for (int i = 0; i < NUM_PERIPHS; i++) begin
      txValid[i] = deliver & (holdAddr == 3'(i));
    end

    pending_d   = rdEn;
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    waitCnt_d   = waitCnt_q;
    if (pending_q) begin
      holdValid_d = 1'b1;
      holdData_d  = bus.fifo_dout;
      waitCnt_d   = '0;
    end else begin
      if (deliver | drop) begin
        holdValid_d = 1'b0;
      end
      if (blocked) begin
        waitCnt_d = waitCnt_q + WaitW'(1);
      end
    end

    dropCount_d = dropCount_q;
    if (drop && (dropCount_q != 16'hFFFF)) begin
      dropCount_d = dropCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pending_q   <= 1'b0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      waitCnt_q   <= '0;
      dropCount_q <= '0;
    end else begin
      pending_q   <= pending_d;
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      waitCnt_q   <= waitCnt_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign bus.fifo_rd_en = rdEn;
  assign bus.tx_data    = holdData_q;
  assign bus.tx_valid   = txValid;
  assign drop_pulse_o   = drop;
  assign drop_count_o   = dropCount_q;
  assign idle_o         = ~holdValid_q & ~pending_q & bus.fifo_empty;

endmodule

// File: tb/tb_usb_rx_router.sv
// Directed bench for usb_rx_router: an 8-port instance with a 16-cycle timeout and a
// 4-port instance for invalid-address drops, each fed by a small FIFO model.
module tb_usb_rx_router;

  logic clk;
  logic rst_l;
  int   nCompared;
  int   nMismatched;

  usb_rx_router_if #(.NUM_PERIPHS(8)) b8 ();
  usb_rx_router_if #(.NUM_PERIPHS(4)) b4 ();

  logic        dropPulse8, dropPulse4;
  logic [15:0] dropCount8, dropCount4;
  logic        idle8, idle4;

  usb_rx_router #(.NUM_PERIPHS(8), .TIMEOUT_CYCLES(16)) dut8 (
    .clk(clk), .rst_l(rst_l), .bus(b8.master),
    .drop_pulse_o(dropPulse8), .drop_count_o(dropCount8), .idle_o(idle8)
  );

  usb_rx_router #(.NUM_PERIPHS(4), .TIMEOUT_CYCLES(16)) dut4 (
    .clk(clk), .rst_l(rst_l), .bus(b4.master),
    .drop_pulse_o(dropPulse4), .drop_count_o(dropCount4), .idle_o(idle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: words appended by the stimulus, popped one cycle after each read strobe.
  logic [31:0] mem8 [64];
  logic [31:0] mem4 [64];
  int pushCnt8 = 0;
  int pushCnt4 = 0;
  int popIdx8  = 0;
  int popIdx4  = 0;

  assign b8.fifo_empty = (popIdx8 >= pushCnt8);
  assign b4.fifo_empty = (popIdx4 >= pushCnt4);

  always @(posedge clk) begin
    if (b8.fifo_rd_en) begin
      b8.fifo_dout <= mem8[popIdx8];
      popIdx8      <= popIdx8 + 1;
    end
    if (b4.fifo_rd_en) begin
      b4.fifo_dout <= mem4[popIdx4];
      popIdx4      <= popIdx4 + 1;
    end
  end

  task automatic applyStimulus(input int which, input logic [31:0] word);
    if (which == 8) begin
      mem8[pushCnt8] = word;
      pushCnt8 = pushCnt8 + 1;
    end else begin
      mem4[pushCnt4] = word;
      pushCnt4 = pushCnt4 + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    b8.fifo_dout = '0;
    b4.fifo_dout = '0;
    b8.tx_full   = '0;
    b4.tx_full   = '0;
    rst_l        = 1'b0;
    tick();
    tick();

    // Reset state, still in reset
    checkOutput("rst_rd_en",   32'(b8.fifo_rd_en), 32'h0);
    checkOutput("rst_valid",   32'(b8.tx_valid),   32'h0);
    checkOutput("rst_data",    b8.tx_data,         32'h0);
    checkOutput("rst_pulse",   32'(dropPulse8),    32'h0);
    checkOutput("rst_count",   32'(dropCount8),    32'h0);
    checkOutput("rst_idle",    32'(idle8),         32'h1);
    rst_l = 1'b1;
    tick();

    // Four words to addresses 0..3, no backpressure
    applyStimulus(8, 32'h0000_00AA);
    applyStimulus(8, 32'h2000_00BB);
    applyStimulus(8, 32'h4000_00CC);
    applyStimulus(8, 32'h6000_00DD);
    #1;
    checkOutput("t1_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    checkOutput("t1_idle",  32'(idle8),         32'h0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] expWord;
      expWord = {3'(k), 29'h0} | (32'hAA + 32'(k) * 32'h11);
      tick();
      checkOutput("t1_gap_valid", 32'(b8.tx_valid), 32'h0);
      tick();
      checkOutput("t1_valid", 32'(b8.tx_valid), 32'h1 << k);
      checkOutput("t1_data",  b8.tx_data,       expWord);
    end
    checkOutput("t1_rd_last", 32'(b8.fifo_rd_en), 32'h0);
    tick();
    checkOutput("t1_idle_end", 32'(idle8),      32'h1);
    checkOutput("t1_count",    32'(dropCount8), 32'h0);

    // Backpressure on port 5 holds the word and blocks further pops
    b8.tx_full = 8'h20;
    applyStimulus(8, 32'hA000_1234);
    applyStimulus(8, 32'h0000_0001);
    #1;
    checkOutput("t2_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      checkOutput("t2_blk_valid", 32'(b8.tx_valid),   32'h0);
      checkOutput("t2_blk_rd_en", 32'(b8.fifo_rd_en), 32'h0);
      checkOutput("t2_blk_pulse", 32'(dropPulse8),    32'h0);
    end
    tick();
    b8.tx_full = 8'h00;
    #1;
    checkOutput("t2_rel_valid", 32'(b8.tx_valid),   32'h20);
    checkOutput("t2_rel_data",  b8.tx_data,         32'hA000_1234);
    checkOutput("t2_rel_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    tick();
    checkOutput("t2_gap_valid", 32'(b8.tx_valid), 32'h0);
    tick();
    checkOutput("t2_next_valid", 32'(b8.tx_valid), 32'h01);
    checkOutput("t2_next_data",  b8.tx_data,       32'h0000_0001);
    tick();

    // Port 2 stuck full: dropped in the 16th held cycle, next word fetched
    b8.tx_full = 8'h04;
    applyStimulus(8, 32'h4000_0077);
    applyStimulus(8, 32'h0000_0055);
    #1;
    checkOutput("t3_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      checkOutput("t3_wait_pulse", 32'(dropPulse8),    32'h0);
      checkOutput("t3_wait_valid", 32'(b8.tx_valid),   32'h0);
      checkOutput("t3_wait_rd_en", 32'(b8.fifo_rd_en), 32'h0);
    end
    tick();
    checkOutput("t3_drop_pulse", 32'(dropPulse8),    32'h1);
    checkOutput("t3_drop_valid", 32'(b8.tx_valid),   32'h0);
    checkOutput("t3_drop_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    tick();
    checkOutput("t3_after_pulse", 32'(dropPulse8), 32'h0);
    checkOutput("t3_count",       32'(dropCount8), 32'h1);
    tick();
    checkOutput("t3_next_valid", 32'(b8.tx_valid), 32'h01);
    checkOutput("t3_next_data",  b8.tx_data,       32'h0000_0055);
    tick();
    b8.tx_full = 8'h00;

    // Four-port instance: address 7 is invalid and dropped at once
    applyStimulus(4, 32'hE000_0000);
    applyStimulus(4, 32'h2000_0042);
    #1;
    checkOutput("t4_rd_en", 32'(b4.fifo_rd_en), 32'h1);
    tick();
    tick();
    checkOutput("t4_drop_pulse", 32'(dropPulse4),    32'h1);
    checkOutput("t4_drop_valid", 32'(b4.tx_valid),   32'h0);
    checkOutput("t4_drop_rd_en", 32'(b4.fifo_rd_en), 32'h1);
    tick();
    checkOutput("t4_after_pulse", 32'(dropPulse4), 32'h0);
    checkOutput("t4_count",       32'(dropCount4), 32'h1);
    tick();
    checkOutput("t4_next_valid", 32'(b4.tx_valid), 32'h2);
    checkOutput("t4_next_data",  b4.tx_data,       32'h2000_0042);
    tick();

    // Reset while a word is held, then reset while a read is in flight
    b8.tx_full = 8'h02;
    applyStimulus(8, 32'h2000_0011);
    applyStimulus(8, 32'h4000_0022);
    applyStimulus(8, 32'h0000_0033);
    #1;
    checkOutput("t5_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    tick();
    tick();
    checkOutput("t5_held_data",  b8.tx_data,         32'h2000_0011);
    checkOutput("t5_held_rd_en", 32'(b8.fifo_rd_en), 32'h0);
    tick();
    tick();
    rst_l = 1'b0;
    tick();
    checkOutput("t5_rst_valid", 32'(b8.tx_valid),   32'h0);
    checkOutput("t5_rst_data",  b8.tx_data,         32'h0);
    checkOutput("t5_rst_pulse", 32'(dropPulse8),    32'h0);
    checkOutput("t5_rst_count", 32'(dropCount8),    32'h0);
    checkOutput("t5_rst_cnt4",  32'(dropCount4),    32'h0);
    checkOutput("t5_rst_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    rst_l = 1'b1;
    tick();
    tick();
    checkOutput("t5_w2_valid", 32'(b8.tx_valid),   32'h04);
    checkOutput("t5_w2_data",  b8.tx_data,         32'h4000_0022);
    checkOutput("t5_w2_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    tick();
    rst_l = 1'b0;
    tick();
    checkOutput("t5_rst2_valid", 32'(b8.tx_valid), 32'h0);
    checkOutput("t5_rst2_data",  b8.tx_data,       32'h0);
    checkOutput("t5_rst2_idle",  32'(idle8),       32'h1);
    rst_l = 1'b1;
    applyStimulus(8, 32'h6000_0044);
    #1;
    checkOutput("t5_new_rd_en", 32'(b8.fifo_rd_en), 32'h1);
    tick();
    tick();
    checkOutput("t5_new_valid", 32'(b8.tx_valid), 32'h08);
    checkOutput("t5_new_data",  b8.tx_data,       32'h6000_0044);
    tick();
    b8.tx_full = 8'h00;

    // Saturation: preload the counter just below its ceiling
    force dut4.dropCount_q = 16'hFFFE;
    tick();
    release dut4.dropCount_q;
    tick();
    checkOutput("t6_preload", 32'(dropCount4), 32'hFFFE);
    applyStimulus(4, 32'hE000_0001);
    applyStimulus(4, 32'hE000_0002);
    tick();
    tick();
    checkOutput("t6_pulse1", 32'(dropPulse4), 32'h1);
    tick();
    checkOutput("t6_gap_pulse", 32'(dropPulse4), 32'h0);
    checkOutput("t6_count1",    32'(dropCount4), 32'hFFFF);
    tick();
    checkOutput("t6_pulse2", 32'(dropPulse4), 32'h1);
    tick();
    checkOutput("t6_count2", 32'(dropCount4), 32'hFFFF);
    checkOutput("t6_idle",   32'(idle4),      32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
